// File: rtl/data_memory_responder.sv
// data_memory_responder: RAM-side responder for the memory pipeline stage.
// Loads return combinationally. Stores are posted into a FIFO store buffer
// that drains into a word-addressed array one entry per cycle, and loads
// forward from the youngest matching buffered store. A program-loader port
// shares the array write port and takes priority over the drain.
// Optional feature macro: DMEM_MMIO_LED_EN (LED register at word 16'hFFFF).
module data_memory_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               memory_read_address,
  input  logic [15:0]               memory_write_address,
  input  logic [15:0]               memory_write_data,
  input  logic                      memory_write,
  output logic [15:0]               memory_data_from_ram,
  output logic                      mem_stall,
  input  logic                      load_valid,
  input  logic [15:0]               load_address,
  input  logic [15:0]               load_data,
  output logic                      load_ready,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_overflow,
  output logic [15:0]               led_out
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [ADDR_BITS-1:0] idx;
    logic [DATA_W-1:0]    data;
  } sb_entry_t;

  sb_entry_t            sb_mem [SB_DEPTH];
  logic [DATA_W-1:0]    mem    [DEPTH];

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  logic [ADDR_BITS-1:0] read_idx;
  logic [ADDR_BITS-1:0] write_idx;
  logic [ADDR_BITS-1:0] loader_idx;

  logic                 sb_full;
  logic                 sb_empty;
  logic                 enq;
  logic                 drain;
  logic                 mmio_wr;
  logic                 mmio_rd;
  logic [15:0]          led_q;

  logic                 fwd_hit;
  logic [DATA_W-1:0]    fwd_data;
  logic [PTR_W-1:0]     fwd_pos;

  // Upper address bits are ignored (aliasing); fold them away explicitly.
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{memory_read_address[15:ADDR_BITS],
                              memory_write_address[15:ADDR_BITS],
                              load_address[15:ADDR_BITS]};

  assign read_idx   = memory_read_address[ADDR_BITS-1:0];
  assign write_idx  = memory_write_address[ADDR_BITS-1:0];
  assign loader_idx = load_address[ADDR_BITS-1:0];

  assign sb_full  = (count == CNT_W'(SB_DEPTH));
  assign sb_empty = (count == '0);

`ifdef DMEM_MMIO_LED_EN
  assign mmio_wr = memory_write && (memory_write_address == 16'hFFFF);
  assign mmio_rd = (memory_read_address == 16'hFFFF);

  // LED register: MMIO stores bypass the buffer and land here directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= '0;
    end else if (mmio_wr) begin
      led_q <= memory_write_data;
    end
  end
`else
  assign mmio_wr = 1'b0;
  assign mmio_rd = 1'b0;
  assign led_q   = 16'h0000;
`endif

  assign led_out    = led_q;
  assign load_ready = 1'b1;

  // Full buffer with the drain slot taken by the loader cannot accept a store.
  assign mem_stall = sb_full && load_valid && !mmio_wr;
  assign enq       = memory_write && !mem_stall && !mmio_wr;
  assign drain     = !sb_empty && !load_valid;

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_pos  = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      fwd_pos = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (sb_mem[fwd_pos].idx == read_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_mem[fwd_pos].data;
      end
    end
  end

  // Load data mux: MMIO register, forwarded store, or array contents.
  always_comb begin
    memory_data_from_ram = mem[read_idx];
    if (mmio_rd) begin
      memory_data_from_ram = led_q;
    end else if (fwd_hit) begin
      memory_data_from_ram = fwd_data;
    end
  end

  // Store-buffer pointers and occupancy; reset discards undrained stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  // Store-buffer payload write at the tail.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      sb_mem[tail] <= '{idx: write_idx, data: memory_write_data};
    end
  end

  // Shared array write port: loader has priority, otherwise drain the head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load_valid) begin
        mem[loader_idx] <= load_data;
      end else if (drain) begin
        mem[sb_mem[head].idx] <= sb_mem[head].data;
      end
    end
  end

  // Sticky flag for stores that arrived while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_overflow <= 1'b0;
    end else if (memory_write && mem_stall) begin
      sb_overflow <= 1'b1;
    end
  end

  assign sb_count = count;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: vector table with a scoreboard queue, plus a few
// hand-written sequences for drain timing and the 16'hFFFF address.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memory_read_address;
  logic [15:0] memory_write_address;
  logic [15:0] memory_write_data;
  logic        memory_write;
  logic [15:0] memory_data_from_ram;
  logic        mem_stall;
  logic        load_valid;
  logic [15:0] load_address;
  logic [15:0] load_data;
  logic        load_ready;
  logic [2:0]  sb_count;
  logic        sb_overflow;
  logic [15:0] led_out;

  int tests = 0;
  int fails = 0;

  data_memory_responder #(.ADDR_BITS(8), .SB_DEPTH(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .memory_read_address  (memory_read_address),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .memory_write         (memory_write),
    .memory_data_from_ram (memory_data_from_ram),
    .mem_stall            (mem_stall),
    .load_valid           (load_valid),
    .load_address         (load_address),
    .load_data            (load_data),
    .load_ready           (load_ready),
    .sb_count             (sb_count),
    .sb_overflow          (sb_overflow),
    .led_out              (led_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [15:0] ra;
    logic        lv;
    logic [15:0] la;
    logic [15:0] ld;
    logic        chk_rd;
    logic [15:0] e_rd;
    logic        e_stall;
    logic [2:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic wr, input logic [15:0] wa, input logic [15:0] wd,
                     input logic [15:0] ra, input logic lv, input logic [15:0] la, input logic [15:0] ld,
                     input logic chk, input logic [15:0] erd, input logic est,
                     input logic [2:0] ecnt, input logic eovf);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wa = wa; v.wd = wd; v.ra = ra;
    v.lv = lv; v.la = la; v.ld = ld; v.chk_rd = chk; v.e_rd = erd;
    v.e_stall = est; v.e_cnt = ecnt; v.e_ovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; memory_write = 1'b0; memory_write_address = '0;
    memory_write_data = '0; memory_read_address = '0;
    load_valid = 1'b0; load_address = '0; load_data = '0;
  endtask

  // Drive at negedge, sample combinational outputs before posedge,
  // registered outputs #1 after it.
  task automatic step(input vec_t v, input int n);
    vec_t e;
    logic [15:0] pre_rd;
    logic        pre_st;
    reset = v.rst; memory_write = v.wr; memory_write_address = v.wa;
    memory_write_data = v.wd; memory_read_address = v.ra;
    load_valid = v.lv; load_address = v.la; load_data = v.ld;
    exp_q.push_back(v);
    #4;
    pre_rd = memory_data_from_ram;
    pre_st = mem_stall;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.chk_rd) check($sformatf("v%0d rdata", n), pre_rd, e.e_rd);
    check($sformatf("v%0d mem_stall", n), 16'(pre_st), 16'(e.e_stall));
    check($sformatf("v%0d sb_count", n), 16'(sb_count), 16'(e.e_cnt));
    check($sformatf("v%0d sb_overflow", n), 16'(sb_overflow), 16'(e.e_ovf));
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    //   rst wr wa      wd       ra      lv la      ld       chk erd      st cnt ovf
    add(1, 0, 16'h0,  16'h0,   16'h0,  0, 16'h0,  16'h0,   0, 16'h0,    0, 0, 0); // 0 reset
    add(0, 0, 16'h0,  16'h0,   16'h0,  1, 16'h05, 16'h1111, 0, 16'h0,   0, 0, 0); // loader init
    add(0, 0, 16'h0,  16'h0,   16'h0,  1, 16'h07, 16'h2222, 0, 16'h0,   0, 0, 0);
    add(0, 0, 16'h0,  16'h0,   16'h0,  1, 16'h09, 16'h3333, 0, 16'h0,   0, 0, 0);
    add(0, 0, 16'h0,  16'h0,   16'h05, 0, 16'h0,  16'h0,   1, 16'h1111, 0, 0, 0);
    add(0, 1, 16'h05, 16'h1234, 16'h05, 0, 16'h0, 16'h0,   1, 16'h1111, 0, 1, 0); // 5 same-cycle not fwd
    add(0, 0, 16'h0,  16'h0,   16'h05, 0, 16'h0,  16'h0,   1, 16'h1234, 0, 0, 0); // forwarded
    add(0, 0, 16'h0,  16'h0,   16'h05, 0, 16'h0,  16'h0,   1, 16'h1234, 0, 0, 0); // from array
    add(0, 0, 16'h0,  16'h0,   16'h05, 0, 16'h0,  16'h0,   1, 16'h1234, 0, 0, 0);
    add(0, 0, 16'h0,  16'h0,   16'h09, 0, 16'h0,  16'h0,   1, 16'h3333, 0, 0, 0);
    add(0, 1, 16'h07, 16'hAAAA, 16'h07, 1, 16'h20, 16'h0,  1, 16'h2222, 0, 1, 0); // 10
    add(0, 1, 16'h07, 16'hBBBB, 16'h07, 1, 16'h20, 16'h0,  1, 16'hAAAA, 0, 2, 0);
    add(0, 0, 16'h0,  16'h0,   16'h07, 1, 16'h20, 16'h0,   1, 16'hBBBB, 0, 2, 0); // youngest wins
    add(0, 1, 16'h10, 16'h00A0, 16'h07, 1, 16'h20, 16'h0,  1, 16'hBBBB, 0, 3, 0);
    add(0, 1, 16'h11, 16'h00A1, 16'h07, 1, 16'h20, 16'h0,  1, 16'hBBBB, 0, 4, 0); // full
    add(0, 1, 16'h12, 16'h00A2, 16'h07, 1, 16'h20, 16'h0,  1, 16'hBBBB, 1, 4, 1); // 15 dropped
    add(0, 0, 16'h0,  16'h0,   16'h07, 0, 16'h0,  16'h0,   1, 16'hBBBB, 0, 3, 1); // drains
    add(0, 0, 16'h0,  16'h0,   16'h07, 0, 16'h0,  16'h0,   1, 16'hBBBB, 0, 2, 1);
    add(0, 0, 16'h0,  16'h0,   16'h10, 0, 16'h0,  16'h0,   1, 16'h00A0, 0, 1, 1);
    add(0, 0, 16'h0,  16'h0,   16'h11, 0, 16'h0,  16'h0,   1, 16'h00A1, 0, 0, 1);
    add(0, 0, 16'h0,  16'h0,   16'h07, 0, 16'h0,  16'h0,   1, 16'hBBBB, 0, 0, 1); // 20 FIFO order
    add(0, 1, 16'h30, 16'h00C0, 16'h0, 1, 16'h20, 16'h0,   0, 16'h0,    0, 1, 1);
    add(0, 1, 16'h31, 16'h00C1, 16'h0, 1, 16'h20, 16'h0,   0, 16'h0,    0, 2, 1);
    add(0, 1, 16'h32, 16'h00C2, 16'h0, 1, 16'h20, 16'h0,   0, 16'h0,    0, 3, 1);
    add(0, 1, 16'h33, 16'h00C3, 16'h0, 1, 16'h20, 16'h0,   0, 16'h0,    0, 4, 1);
    add(0, 1, 16'h34, 16'h00C4, 16'h30, 0, 16'h0, 16'h0,   1, 16'h00C0, 0, 4, 1); // 25 enq+drain full
    add(0, 0, 16'h0,  16'h0,   16'h34, 0, 16'h0,  16'h0,   1, 16'h00C4, 0, 3, 1);
    add(0, 0, 16'h0,  16'h0,   16'h30, 0, 16'h0,  16'h0,   1, 16'h00C0, 0, 2, 1);
    add(0, 0, 16'h0,  16'h0,   16'h31, 0, 16'h0,  16'h0,   1, 16'h00C1, 0, 1, 1);
    add(0, 0, 16'h0,  16'h0,   16'h33, 0, 16'h0,  16'h0,   1, 16'h00C3, 0, 0, 1);
    add(0, 0, 16'h0,  16'h0,   16'h34, 0, 16'h0,  16'h0,   1, 16'h00C4, 0, 0, 1); // 30
    add(0, 0, 16'h0,  16'h0,   16'h0,  1, 16'h40, 16'h4444, 0, 16'h0,   0, 0, 1);
    add(0, 1, 16'h40, 16'hDEAD, 16'h0, 1, 16'h20, 16'h0,   0, 16'h0,    0, 1, 1);
    add(0, 1, 16'h41, 16'hBEEF, 16'h40, 1, 16'h20, 16'h0,  1, 16'hDEAD, 0, 2, 1);
    add(1, 1, 16'h40, 16'h7777, 16'h40, 1, 16'h40, 16'h9999, 1, 16'hDEAD, 0, 0, 0); // reset mid-op
    add(0, 0, 16'h0,  16'h0,   16'h40, 0, 16'h0,  16'h0,   1, 16'h4444, 0, 0, 0); // 35
    add(0, 0, 16'h0,  16'h0,   16'h0,  1, 16'h1105, 16'h5555, 0, 16'h0, 0, 0, 0); // aliasing
    add(0, 0, 16'h0,  16'h0,   16'h0205, 0, 16'h0, 16'h0,  1, 16'h5555, 0, 0, 0);
    add(0, 1, 16'h60, 16'h6060, 16'h0, 1, 16'h20, 16'h0,   0, 16'h0,    0, 1, 0);
    add(0, 0, 16'h0,  16'h0,   16'h60, 1, 16'h60, 16'h0606, 1, 16'h6060, 0, 1, 0);
    add(0, 0, 16'h0,  16'h0,   16'h60, 0, 16'h0,  16'h0,   1, 16'h6060, 0, 0, 0); // 40
    add(0, 0, 16'h0,  16'h0,   16'h60, 0, 16'h0,  16'h0,   1, 16'h6060, 0, 0, 0); // drain beats loader

    @(negedge clk);
    foreach (vecs[i]) step(vecs[i], i);
    check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
    check("load_ready", 16'(load_ready), 16'h1);

    // Single store drains within a bounded number of cycles.
    idle_inputs();
    memory_write = 1'b1; memory_write_address = 16'h70; memory_write_data = 16'h7070;
    @(posedge clk); #1;
    check("post_store_count", 16'(sb_count), 16'h1);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i < 4 && sb_count != 3'd0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_timeout_count", 16'(sb_count), 16'h0);
    @(negedge clk);
    memory_read_address = 16'h70;
    #1;
    check("drained_value", memory_data_from_ram, 16'h7070);

`ifdef DMEM_MMIO_LED_EN
    // LED register store bypasses the buffer.
    idle_inputs();
    @(negedge clk);
    memory_write = 1'b1; memory_write_address = 16'hFFFF; memory_write_data = 16'h00FF;
    @(posedge clk); #1;
    check("mmio_led_out", led_out, 16'h00FF);
    check("mmio_sb_count", 16'(sb_count), 16'h0);
    @(negedge clk);
    idle_inputs();
    memory_read_address = 16'hFFFF;
    #1;
    check("mmio_load", memory_data_from_ram, 16'h00FF);
`else
    // 16'hFFFF is an ordinary aliased array word; LED output stays zero.
    idle_inputs();
    @(negedge clk);
    memory_write = 1'b1; memory_write_address = 16'hFFFF; memory_write_data = 16'hABCD;
    @(posedge clk); #1;
    check("alias_store_count", 16'(sb_count), 16'h1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    memory_read_address = 16'h00FF;
    #1;
    check("alias_ffff_load", memory_data_from_ram, 16'hABCD);
    check("led_out_tied", led_out, 16'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
